engine_feeder: RTL and testbench
================================

# engine_feeder

Write-side feeder for the engine's operand FIFOs. Accepts a 32-bit DMA read stream carrying packed FP16 operands, unpacks each beat into two 16-bit elements and pushes them into the port-0/port-1 data and weight FIFOs that the engine drains, routed by operation type. It loads the weight phase, then the data phase, and throttles on FIFO full and stream valid.

## Interface
Parameters:
- LEN_W, 32, width of length counters

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle command pulse, sampled only in IDLE
- op_type  in  3  1=CONV1, 2=CONV3, 3=CONVP, 4=MPOOL, 5=APOOL; latched at start
- weight_len  in  LEN_W  weight elements per port; latched at start
- data_len  in  LEN_W  data elements; latched at start
- s_valid  in  1  stream beat valid
- s_data  in  32  beat; [15:0] first element, [31:16] second
- s_ready  out  1  beat accepted when s_valid && s_ready
- p0_data_din, p0_weight_din, p1_data_din, p1_weight_din  out  16 each  FIFO write data
- p0_data_wr_en, p0_weight_wr_en, p1_data_wr_en, p1_weight_wr_en  out  1 each  FIFO write strobes
- p0_data_full, p0_weight_full, p1_data_full, p1_weight_full  in  1 each  FIFO full flags
- busy  out  1  command in progress
- done  out  1  one-cycle pulse, all elements written

## Operation
- States: IDLE, WEIGHT, DATA, DONE.
- IDLE: start latches op_type, weight_len, data_len; clears counters and hold buffer. Next: WEIGHT if weight_len≠0 and op_type∈{1,2,3}; else DATA if data_len≠0; else DONE. Unknown op_type (0,6,7): goes straight to DONE.
- Hold buffer: 32-bit register plus hold_lo/hold_hi valid bits, loaded on accepted beat.
- Routing: CONV1 → p1 FIFOs; CONV3 → p0 FIFOs; MPOOL/APOOL → p0 data only, WEIGHT skipped.
- Non-CONVP phases: serial; low half written, then high half, one element per cycle to the selected FIFO. Element counter counts to phase length. If length is odd, the final beat's high half is discarded (hold_hi cleared, not written).
- CONVP WEIGHT: each beat is one weight per port; low half → p0_weight, high half → p1_weight, both written in the same cycle. Requires both FIFOs not full. weight_len beats.
- CONVP DATA: each element is written to p0_data and p1_data simultaneously, low then high. Requires both FIFOs not full. data_len elements.
- wr_en = current element valid && phase/route match && target FIFO(s) not full. Combinational. din = the corresponding hold half. Unselected din = 16'h0000.
- s_ready = in WEIGHT/DATA && remaining beats > 0 && (hold empty || the last held element is written this cycle). Gives one element/cycle sustained.
- Phase ends when its counter reaches its length on a write. Then WEIGHT→DATA (or DONE if data_len=0), DATA→DONE.
- DONE: done=1 for one cycle, then IDLE.
- busy = state≠IDLE.
- start while busy: ignored.

## Timing
- Reset values: s_ready=0, all wr_en=0, all din=0, busy=0, done=0, state IDLE, hold empty.
- Reset mid-operation: abort immediately. Held beat and counters are discarded; no further writes.
- start→first s_ready: 1 cycle (s_ready high the cycle after start).
- Beat accepted at cycle t → first wr_en at t+1, if not full.
- Full asserted: wr_en stays low and the element is held; no loss and no duplication. The write occurs the first cycle full deasserts.
- s_valid low with hold empty: no write, counters frozen.
- Last write at cycle t → state DONE at t+1 (done=1) → IDLE at t+2. A start at t+2 is accepted.
- Both lengths zero: done 1 cycle after start.

## Test plan
- CONV3, weight_len=4, data_len=4, beats W:{0x0002_0001,0x0004_0003}, D:{0x0012_0011,0x0014_0013}, never full → p0_weight gets 1,2,3,4 then p0_data gets 11,12,13,14 on consecutive cycles; p1 strobes never high; done once.
- CONVP, weight_len=2, data_len=2, W:{0xB000_A000,0xB001_A001}, D:{0x0D02_0D01} → p0_weight A000,A001 and p1_weight B000,B001 in paired cycles; both data FIFOs get 0D01 then 0D02 in the same cycles.
- CONV1, data_len=3 odd, weight_len=0 → p1_data gets 3 elements; the high half of the 2nd beat is dropped; only 2 beats accepted.
- MPOOL, data_len=4, p0_data_full high for 5 cycles mid-stream → wr_en low during full, s_ready back-pressures, output sequence is intact with no duplicates.
- rst asserted after 2 of 8 data writes, then start a new CONV3 command → no writes after reset; the new command's sequence is correct from its first element.
- start with both lengths 0, and start pulsed while busy → done one cycle after the first start; the second start is ignored.

Source files
------------

// File: rtl/engine_feeder.sv
// rtl/engine_feeder.sv - unpacks 32-bit FP16 operand beats into the engine's port-0/port-1 data and weight FIFOs
module engine_feeder #(
    parameter int LEN_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op_type,
    input  logic [LEN_W-1:0] weight_len,
    input  logic [LEN_W-1:0] data_len,
    input  logic             s_valid,
    input  logic [31:0]      s_data,
    output logic             s_ready,
    output logic [15:0]      p0_data_din,
    output logic [15:0]      p0_weight_din,
    output logic [15:0]      p1_data_din,
    output logic [15:0]      p1_weight_din,
    output logic             p0_data_wr_en,
    output logic             p0_weight_wr_en,
    output logic             p1_data_wr_en,
    output logic             p1_weight_wr_en,
    input  logic             p0_data_full,
    input  logic             p0_weight_full,
    input  logic             p1_data_full,
    input  logic             p1_weight_full,
    output logic             busy,
    output logic             done
);
    localparam logic [2:0] OP_CONV1 = 3'd1;
    localparam logic [2:0] OP_CONV3 = 3'd2;
    localparam logic [2:0] OP_CONVP = 3'd3;
    localparam logic [2:0] OP_MPOOL = 3'd4;
    localparam logic [2:0] OP_APOOL = 3'd5;
    localparam logic [LEN_W-1:0] ONE = {{(LEN_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {S_IDLE, S_WEIGHT, S_DATA, S_DONE} state_t;

    state_t           r_state, w_state_nx;
    logic [2:0]       r_op;
    logic [LEN_W-1:0] r_wlen, r_dlen, r_elem_cnt, r_beat_cnt;
    logic [31:0]      r_hold;
    logic             r_hold_lo, r_hold_hi;

    logic             w_in_phase, w_pair;
    logic [LEN_W-1:0] w_len, w_elem_nx;
    logic [LEN_W:0]   w_beats_needed;
    logic             w_sel_p0d, w_sel_p1d, w_sel_p0w, w_sel_p1w;
    logic             w_blocked, w_elem_valid, w_write, w_last, w_drain, w_accept;
    logic             w_hold_lo_nx, w_hold_hi_nx;
    logic [15:0]      w_elem;

    assign w_in_phase = (r_state == S_WEIGHT) || (r_state == S_DATA);
    assign w_pair     = (r_state == S_WEIGHT) && (r_op == OP_CONVP);
    assign w_len      = (r_state == S_WEIGHT) ? r_wlen : r_dlen;
    assign w_elem_nx  = r_elem_cnt + ONE;
    // Paired weight phase counts beats; every other phase counts 16-bit elements.
    assign w_beats_needed = w_pair ? {1'b0, w_len}
                                   : (({1'b0, w_len} + {{LEN_W{1'b0}}, 1'b1}) >> 1);

    always_comb begin
        w_sel_p0d = 1'b0;
        w_sel_p1d = 1'b0;
        w_sel_p0w = 1'b0;
        w_sel_p1w = 1'b0;
        if (r_state == S_WEIGHT) begin
            case (r_op)
                OP_CONV1: w_sel_p1w = 1'b1;
                OP_CONV3: w_sel_p0w = 1'b1;
                OP_CONVP: begin w_sel_p0w = 1'b1; w_sel_p1w = 1'b1; end
                default: ;
            endcase
        end else if (r_state == S_DATA) begin
            case (r_op)
                OP_CONV1:                     w_sel_p1d = 1'b1;
                OP_CONV3, OP_MPOOL, OP_APOOL: w_sel_p0d = 1'b1;
                OP_CONVP: begin w_sel_p0d = 1'b1; w_sel_p1d = 1'b1; end
                default: ;
            endcase
        end
    end

    assign w_blocked    = (w_sel_p0d && p0_data_full) || (w_sel_p1d && p1_data_full) ||
                          (w_sel_p0w && p0_weight_full) || (w_sel_p1w && p1_weight_full);
    assign w_elem_valid = w_pair ? (r_hold_lo && r_hold_hi) : (r_hold_lo || r_hold_hi);
    assign w_write      = w_elem_valid && !w_blocked &&
                          (w_sel_p0d || w_sel_p1d || w_sel_p0w || w_sel_p1w);
    assign w_last       = w_write && (w_elem_nx == w_len);
    assign w_elem       = r_hold_lo ? r_hold[15:0] : r_hold[31:16];

    // An odd-length phase drops the high half of its final beat.
    always_comb begin
        w_hold_lo_nx = r_hold_lo;
        w_hold_hi_nx = r_hold_hi;
        if (w_write) begin
            if (w_pair) begin
                w_hold_lo_nx = 1'b0;
                w_hold_hi_nx = 1'b0;
            end else if (r_hold_lo) begin
                w_hold_lo_nx = 1'b0;
                if (w_last) w_hold_hi_nx = 1'b0;
            end else begin
                w_hold_hi_nx = 1'b0;
            end
        end
    end

    assign w_drain  = w_write && !w_hold_lo_nx && !w_hold_hi_nx;
    assign s_ready  = w_in_phase && ({1'b0, r_beat_cnt} < w_beats_needed) &&
                      ((!r_hold_lo && !r_hold_hi) || w_drain);
    assign w_accept = s_valid && s_ready;

    assign p0_data_din     = (w_sel_p0d && w_elem_valid) ? w_elem : 16'h0000;
    assign p1_data_din     = (w_sel_p1d && w_elem_valid) ? w_elem : 16'h0000;
    assign p0_weight_din   = (w_sel_p0w && w_elem_valid) ? w_elem : 16'h0000;
    assign p1_weight_din   = (w_sel_p1w && w_elem_valid) ? (w_pair ? r_hold[31:16] : w_elem) : 16'h0000;
    assign p0_data_wr_en   = w_sel_p0d && w_write;
    assign p1_data_wr_en   = w_sel_p1d && w_write;
    assign p0_weight_wr_en = w_sel_p0w && w_write;
    assign p1_weight_wr_en = w_sel_p1w && w_write;
    assign busy            = (r_state != S_IDLE);
    assign done            = (r_state == S_DONE);

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (weight_len != '0 && op_type >= OP_CONV1 && op_type <= OP_CONVP)
                        w_state_nx = S_WEIGHT;
                    else if (data_len != '0 && op_type >= OP_CONV1 && op_type <= OP_APOOL)
                        w_state_nx = S_DATA;
                    else
                        w_state_nx = S_DONE;
                end
            end
            S_WEIGHT: if (w_last) w_state_nx = (r_dlen != '0) ? S_DATA : S_DONE;
            S_DATA:   if (w_last) w_state_nx = S_DONE;
            S_DONE:   w_state_nx = S_IDLE;
            default:  w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_op       <= 3'd0;
            r_wlen     <= '0;
            r_dlen     <= '0;
            r_elem_cnt <= '0;
            r_beat_cnt <= '0;
            r_hold     <= 32'h0;
            r_hold_lo  <= 1'b0;
            r_hold_hi  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            if (r_state == S_IDLE) begin
                if (start) begin
                    r_op       <= op_type;
                    r_wlen     <= weight_len;
                    r_dlen     <= data_len;
                    r_elem_cnt <= '0;
                    r_beat_cnt <= '0;
                    r_hold     <= 32'h0;
                    r_hold_lo  <= 1'b0;
                    r_hold_hi  <= 1'b0;
                end
            end else if (w_last) begin
                r_elem_cnt <= '0;
                r_beat_cnt <= '0;
                r_hold_lo  <= 1'b0;
                r_hold_hi  <= 1'b0;
            end else begin
                if (w_write) r_elem_cnt <= w_elem_nx;
                if (w_accept) begin
                    r_hold     <= s_data;
                    r_hold_lo  <= 1'b1;
                    r_hold_hi  <= 1'b1;
                    r_beat_cnt <= r_beat_cnt + ONE;
                end else begin
                    r_hold_lo  <= w_hold_lo_nx;
                    r_hold_hi  <= w_hold_hi_nx;
                end
            end
        end
    end
endmodule

// File: tb/tb_engine_feeder.sv
// tb/tb_engine_feeder.sv - directed self-checking bench for engine_feeder
module tb_engine_feeder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op_type = 3'd0;
    logic [31:0] weight_len = 32'd0;
    logic [31:0] data_len = 32'd0;
    logic        s_valid = 1'b0;
    logic [31:0] s_data = 32'h0;
    logic        s_ready;
    logic [15:0] p0_data_din, p0_weight_din, p1_data_din, p1_weight_din;
    logic        p0_data_wr_en, p0_weight_wr_en, p1_data_wr_en, p1_weight_wr_en;
    logic        p0_data_full = 1'b0;
    logic        p0_weight_full = 1'b0;
    logic        p1_data_full = 1'b0;
    logic        p1_weight_full = 1'b0;
    logic        busy, done;

    engine_feeder #(.LEN_W(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op_type(op_type),
        .weight_len(weight_len), .data_len(data_len),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .p0_data_din(p0_data_din), .p0_weight_din(p0_weight_din),
        .p1_data_din(p1_data_din), .p1_weight_din(p1_weight_din),
        .p0_data_wr_en(p0_data_wr_en), .p0_weight_wr_en(p0_weight_wr_en),
        .p1_data_wr_en(p1_data_wr_en), .p1_weight_wr_en(p1_weight_wr_en),
        .p0_data_full(p0_data_full), .p0_weight_full(p0_weight_full),
        .p1_data_full(p1_data_full), .p1_weight_full(p1_weight_full),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [15:0] q_p0d[$], q_p1d[$], q_p0w[$], q_p1w[$];
    int          t_p0d[$], t_p1d[$], t_p0w[$], t_p1w[$];
    logic [31:0] beats_q[$];
    int done_cnt, done_cyc, accepted, n_wr, wr_while_full, ready_while_full;
    int busy_c1, busy_after_done;

    // Cycle 0 carries the start pulse; outputs are sampled on the falling edge.
    task automatic run_cmd(input logic [2:0] op, input logic [31:0] wl, input logic [31:0] dl,
                           input int full_from, input int full_len, input int second_start,
                           input int rst_after, input int max_cyc);
        int cyc;
        logic acc;
        logic [31:0] tmp;
        bit did_rst;
        q_p0d.delete(); q_p1d.delete(); q_p0w.delete(); q_p1w.delete();
        t_p0d.delete(); t_p1d.delete(); t_p0w.delete(); t_p1w.delete();
        done_cnt = 0; done_cyc = -100; accepted = 0; n_wr = 0;
        wr_while_full = 0; ready_while_full = 0; busy_c1 = -1; busy_after_done = -1;
        cyc = 0; did_rst = 0;
        op_type = op; weight_len = wl; data_len = dl; start = 1'b1;
        s_valid = (beats_q.size() > 0);
        s_data  = s_valid ? beats_q[0] : 32'h0;
        p0_data_full = (full_from <= 0) && (0 < full_from + full_len);
        while (cyc < max_cyc && !(done_cnt > 0 && cyc > done_cyc + 2)) begin
            @(negedge clk);
            acc = s_valid && s_ready;
            if (p0_data_wr_en)   begin q_p0d.push_back(p0_data_din);   t_p0d.push_back(cyc); n_wr++; end
            if (p1_data_wr_en)   begin q_p1d.push_back(p1_data_din);   t_p1d.push_back(cyc); n_wr++; end
            if (p0_weight_wr_en) begin q_p0w.push_back(p0_weight_din); t_p0w.push_back(cyc); n_wr++; end
            if (p1_weight_wr_en) begin q_p1w.push_back(p1_weight_din); t_p1w.push_back(cyc); n_wr++; end
            if (p0_data_full && p0_data_wr_en) wr_while_full++;
            if (p0_data_full && s_ready) ready_while_full++;
            if (done) begin
                if (done_cnt == 0) done_cyc = cyc;
                done_cnt++;
            end
            if (cyc == 1) busy_c1 = int'(busy);
            if (done_cnt > 0 && cyc == done_cyc + 1) busy_after_done = int'(busy);
            @(posedge clk);
            #1;
            if (acc) begin tmp = beats_q.pop_front(); accepted++; end
            if (rst) rst = 1'b0;
            else if (rst_after > 0 && n_wr >= rst_after && !did_rst) begin rst = 1'b1; did_rst = 1; end
            cyc++;
            start = (cyc == second_start);
            s_valid = (beats_q.size() > 0);
            s_data  = s_valid ? beats_q[0] : 32'h0;
            p0_data_full = (cyc >= full_from) && (cyc < full_from + full_len);
        end
        start = 1'b0; s_valid = 1'b0; s_data = 32'h0; p0_data_full = 1'b0; rst = 1'b0;
        beats_q.delete();
    endtask

    task automatic test_reset;
        @(negedge clk);
        checks++; if (s_ready !== 1'b0) begin failures++; $display("FAIL reset_s_ready got=%b exp=0", s_ready); end
        checks++; if ({p0_data_wr_en, p1_data_wr_en, p0_weight_wr_en, p1_weight_wr_en} !== 4'b0000) begin
            failures++; $display("FAIL reset_wr_en got=%b exp=0000", {p0_data_wr_en, p1_data_wr_en, p0_weight_wr_en, p1_weight_wr_en}); end
        checks++; if ({p0_data_din, p1_data_din, p0_weight_din, p1_weight_din} !== 64'h0) begin
            failures++; $display("FAIL reset_din got=%h exp=0", {p0_data_din, p1_data_din, p0_weight_din, p1_weight_din}); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        @(posedge clk); #1; rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_conv3;
        logic [15:0] ew[4] = '{16'h0001, 16'h0002, 16'h0003, 16'h0004};
        logic [15:0] ed[4] = '{16'h0011, 16'h0012, 16'h0013, 16'h0014};
        beats_q = '{32'h0002_0001, 32'h0004_0003, 32'h0012_0011, 32'h0014_0013};
        run_cmd(3'd2, 32'd4, 32'd4, 1000, 0, 0, 0, 60);
        checks++; if (q_p0w.size() != 4) begin failures++; $display("FAIL conv3_w_count got=%0d exp=4", q_p0w.size()); end
        for (int i = 0; i < 4 && i < q_p0w.size(); i++) begin
            checks++; if (q_p0w[i] !== ew[i]) begin failures++; $display("FAIL conv3_w[%0d] got=%h exp=%h", i, q_p0w[i], ew[i]); end
        end
        checks++; if (q_p0d.size() != 4) begin failures++; $display("FAIL conv3_d_count got=%0d exp=4", q_p0d.size()); end
        for (int i = 0; i < 4 && i < q_p0d.size(); i++) begin
            checks++; if (q_p0d[i] !== ed[i]) begin failures++; $display("FAIL conv3_d[%0d] got=%h exp=%h", i, q_p0d[i], ed[i]); end
        end
        if (t_p0w.size() == 4 && t_p0d.size() == 4) begin
            checks++; if (t_p0w[0] != 2 || t_p0w[3] != 5) begin failures++; $display("FAIL conv3_w_timing got=%0d..%0d exp=2..5", t_p0w[0], t_p0w[3]); end
            checks++; if (t_p0d[0] != 7 || t_p0d[3] != 10) begin failures++; $display("FAIL conv3_d_timing got=%0d..%0d exp=7..10", t_p0d[0], t_p0d[3]); end
        end
        checks++; if (q_p1d.size() + q_p1w.size() != 0) begin failures++; $display("FAIL conv3_p1_strobes got=%0d exp=0", q_p1d.size() + q_p1w.size()); end
        checks++; if (done_cnt != 1) begin failures++; $display("FAIL conv3_done_count got=%0d exp=1", done_cnt); end
        checks++; if (done_cyc != 11) begin failures++; $display("FAIL conv3_done_cycle got=%0d exp=11", done_cyc); end
        checks++; if (busy_c1 != 1 || busy_after_done != 0) begin
            failures++; $display("FAIL conv3_busy got=%0d/%0d exp=1/0", busy_c1, busy_after_done); end
    endtask

    task automatic test_convp;
        logic [15:0] e0w[2] = '{16'hA000, 16'hA001};
        logic [15:0] e1w[2] = '{16'hB000, 16'hB001};
        logic [15:0] ed[2]  = '{16'h0D01, 16'h0D02};
        beats_q = '{32'hB000_A000, 32'hB001_A001, 32'h0D02_0D01};
        run_cmd(3'd3, 32'd2, 32'd2, 1000, 0, 0, 0, 60);
        checks++; if (q_p0w.size() != 2 || q_p1w.size() != 2 || q_p0d.size() != 2 || q_p1d.size() != 2) begin
            failures++; $display("FAIL convp_counts got=%0d/%0d/%0d/%0d exp=2/2/2/2", q_p0w.size(), q_p1w.size(), q_p0d.size(), q_p1d.size()); end
        else begin
            for (int i = 0; i < 2; i++) begin
                checks++; if (q_p0w[i] !== e0w[i] || q_p1w[i] !== e1w[i] || t_p0w[i] != t_p1w[i]) begin
                    failures++; $display("FAIL convp_w[%0d] got=%h/%h@%0d/%0d exp=%h/%h paired", i, q_p0w[i], q_p1w[i], t_p0w[i], t_p1w[i], e0w[i], e1w[i]); end
                checks++; if (q_p0d[i] !== ed[i] || q_p1d[i] !== ed[i] || t_p0d[i] != t_p1d[i]) begin
                    failures++; $display("FAIL convp_d[%0d] got=%h/%h@%0d/%0d exp=%h paired", i, q_p0d[i], q_p1d[i], t_p0d[i], t_p1d[i], ed[i]); end
            end
        end
        checks++; if (done_cnt != 1 || done_cyc != 7) begin failures++; $display("FAIL convp_done got=%0d@%0d exp=1@7", done_cnt, done_cyc); end
    endtask

    task automatic test_odd_len;
        logic [15:0] ed[3] = '{16'h0031, 16'h0032, 16'h0033};
        beats_q = '{32'h0032_0031, 32'h0034_0033, 32'h0036_0035};
        run_cmd(3'd1, 32'd0, 32'd3, 1000, 0, 2, 0, 60);
        checks++; if (q_p1d.size() != 3) begin failures++; $display("FAIL odd_count got=%0d exp=3", q_p1d.size()); end
        for (int i = 0; i < 3 && i < q_p1d.size(); i++) begin
            checks++; if (q_p1d[i] !== ed[i]) begin failures++; $display("FAIL odd_d[%0d] got=%h exp=%h", i, q_p1d[i], ed[i]); end
        end
        checks++; if (accepted != 2) begin failures++; $display("FAIL odd_beats got=%0d exp=2", accepted); end
        checks++; if (n_wr != 3) begin failures++; $display("FAIL odd_total_writes got=%0d exp=3", n_wr); end
        checks++; if (done_cnt != 1 || done_cyc != 5) begin failures++; $display("FAIL odd_done got=%0d@%0d exp=1@5", done_cnt, done_cyc); end
    endtask

    task automatic test_full_backpressure;
        logic [15:0] ed[4] = '{16'h0021, 16'h0022, 16'h0023, 16'h0024};
        beats_q = '{32'h0022_0021, 32'h0024_0023};
        run_cmd(3'd4, 32'd5, 32'd4, 3, 5, 0, 0, 60);
        checks++; if (q_p0d.size() != 4) begin failures++; $display("FAIL full_count got=%0d exp=4", q_p0d.size()); end
        for (int i = 0; i < 4 && i < q_p0d.size(); i++) begin
            checks++; if (q_p0d[i] !== ed[i]) begin failures++; $display("FAIL full_d[%0d] got=%h exp=%h", i, q_p0d[i], ed[i]); end
        end
        checks++; if (wr_while_full != 0) begin failures++; $display("FAIL full_wr_en got=%0d exp=0", wr_while_full); end
        checks++; if (ready_while_full != 0) begin failures++; $display("FAIL full_s_ready got=%0d exp=0", ready_while_full); end
        checks++; if (t_p0d.size() == 4 && t_p0d[1] != 8) begin failures++; $display("FAIL full_resume got=%0d exp=8", t_p0d[1]); end
        checks++; if (n_wr != 4) begin failures++; $display("FAIL full_pool_weights got=%0d exp=4", n_wr); end
        checks++; if (done_cnt != 1 || done_cyc != 11) begin failures++; $display("FAIL full_done got=%0d@%0d exp=1@11", done_cnt, done_cyc); end
    endtask

    task automatic test_reset_midop;
        logic [15:0] ew[2] = '{16'h0051, 16'h0052};
        logic [15:0] ed[2] = '{16'h0061, 16'h0062};
        beats_q = '{32'h0042_0041, 32'h0044_0043, 32'h0046_0045, 32'h0048_0047};
        run_cmd(3'd2, 32'd0, 32'd8, 1000, 0, 0, 2, 15);
        checks++; if (q_p0d.size() != 2) begin failures++; $display("FAIL abort_writes got=%0d exp=2", q_p0d.size()); end
        checks++; if (done_cnt != 0) begin failures++; $display("FAIL abort_done got=%0d exp=0", done_cnt); end
        @(negedge clk);
        checks++; if (busy !== 1'b0 || s_ready !== 1'b0) begin failures++; $display("FAIL abort_idle got=%b/%b exp=0/0", busy, s_ready); end
        @(posedge clk); #1;
        beats_q = '{32'h0052_0051, 32'h0062_0061};
        run_cmd(3'd2, 32'd2, 32'd2, 1000, 0, 0, 0, 60);
        checks++; if (q_p0w.size() != 2 || q_p0d.size() != 2) begin
            failures++; $display("FAIL after_abort_counts got=%0d/%0d exp=2/2", q_p0w.size(), q_p0d.size()); end
        else begin
            for (int i = 0; i < 2; i++) begin
                checks++; if (q_p0w[i] !== ew[i] || q_p0d[i] !== ed[i]) begin
                    failures++; $display("FAIL after_abort[%0d] got=%h/%h exp=%h/%h", i, q_p0w[i], q_p0d[i], ew[i], ed[i]); end
            end
            checks++; if (t_p0w[0] != 2) begin failures++; $display("FAIL after_abort_first got=%0d exp=2", t_p0w[0]); end
        end
    endtask

    task automatic test_zero_and_busy_start;
        run_cmd(3'd2, 32'd0, 32'd0, 1000, 0, 1, 0, 20);
        checks++; if (done_cnt != 1 || done_cyc != 1) begin failures++; $display("FAIL zero_done got=%0d@%0d exp=1@1", done_cnt, done_cyc); end
        checks++; if (busy_after_done != 0) begin failures++; $display("FAIL zero_busy got=%0d exp=0", busy_after_done); end
        checks++; if (n_wr != 0) begin failures++; $display("FAIL zero_writes got=%0d exp=0", n_wr); end
        beats_q = '{32'h0072_0071};
        run_cmd(3'd6, 32'd4, 32'd4, 1000, 0, 0, 0, 20);
        checks++; if (done_cnt != 1 || done_cyc != 1 || n_wr != 0 || accepted != 0) begin
            failures++; $display("FAIL bad_op got=done%0d@%0d wr%0d acc%0d exp=done1@1 wr0 acc0", done_cnt, done_cyc, n_wr, accepted); end
    endtask

    initial begin
        test_reset();
        test_conv3();
        test_convp();
        test_odd_len();
        test_full_backpressure();
        test_reset_midop();
        test_zero_and_busy_start();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
